// File: rtl/pipeline_trace_capture_pkg.sv
// Shared definitions for the pipeline trace capture unit: FSM encoding,
// default parameters, derived widths and entry field layout {ts, ch, value}.
package pipeline_trace_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    localparam int unsigned DEF_NUM_CH   = 5;
    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_DEPTH    = 16;
    localparam int unsigned DEF_TS_W     = 16;
    localparam int unsigned DEF_POST_CNT = 8;

    function automatic int unsigned ch_width(input int unsigned num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int unsigned entry_width(input int unsigned ts_w,
                                                input int unsigned ch_w,
                                                input int unsigned data_w);
        return ts_w + ch_w + data_w;
    endfunction

    // Value occupies the low bits, channel id sits above it, timestamp on top.
    localparam int unsigned VALUE_LSB = 0;

    function automatic int unsigned ch_lsb(input int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned ts_lsb(input int unsigned data_w,
                                           input int unsigned ch_w);
        return data_w + ch_w;
    endfunction

endpackage

// File: rtl/pipeline_trace_capture_ring_buffer.sv
// Circular entry store for the trace unit: write-with-overwrite of the oldest
// entry when full, and pop of the oldest entry.
module trace_ring_buffer
    import pipeline_trace_capture_pkg::*;
#(
    parameter  int unsigned WIDTH = 64,
    parameter  int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned AW    = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      count,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign pop     = rd_en && (count != '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en && !clear) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            unique case ({wr_en, pop})
                2'b10: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    // When full the write lands on the oldest slot, so the
                    // read side must step past it to keep ordering intact.
                    if (full) begin
                        rd_ptr <= rd_ptr + 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                2'b01: begin
                    rd_ptr <= rd_ptr + 1'b1;
                    count  <= count - 1'b1;
                end
                2'b11: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    rd_ptr <= rd_ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pipeline_trace_capture.sv
// Trace unit that records value changes on watched channels into a ring buffer,
// with arm/trigger/post-trigger control and a request/valid drain port.
module pipeline_trace_capture
    import pipeline_trace_capture_pkg::*;
#(
    parameter  int unsigned NUM_CH   = DEF_NUM_CH,
    parameter  int unsigned DATA_W   = DEF_DATA_W,
    parameter  int unsigned DEPTH    = DEF_DEPTH,
    parameter  int unsigned TS_W     = DEF_TS_W,
    parameter  int unsigned POST_CNT = DEF_POST_CNT,
    localparam int unsigned CH_W     = ch_width(NUM_CH),
    localparam int unsigned AW       = addr_width(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     trig,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic                     rd_req,
    output logic                     rd_valid,
    output logic [TS_W-1:0]          rd_ts,
    output logic [CH_W-1:0]          rd_ch,
    output logic [DATA_W-1:0]        rd_value,
    output logic [AW:0]              count,
    output logic [1:0]               state,
    output logic                     overflow
);

    localparam int unsigned ENTRY_W = entry_width(TS_W, CH_W, DATA_W);
    localparam int unsigned CH_LSB  = ch_lsb(DATA_W);
    localparam int unsigned TS_LSB  = ts_lsb(DATA_W, CH_W);

    trace_state_e              state_q;
    logic [TS_W-1:0]           ts;
    logic [NUM_CH*DATA_W-1:0]  shadow;
    logic [NUM_CH-1:0]         grant;
    logic                      found;
    logic [CH_W-1:0]           sel;
    logic [DATA_W-1:0]         sel_value;
    logic [AW:0]               remaining;
    logic                      capturing;
    logic                      cap;
    logic                      rd_en;
    logic                      full;
    logic [ENTRY_W-1:0]        wr_entry;
    logic [ENTRY_W-1:0]        rd_entry;

    assign state = state_q;

    // Lowest-index pending channel wins; others stay pending for later cycles.
    always_comb begin
        grant     = '0;
        found     = 1'b0;
        sel       = '0;
        sel_value = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!found && ch_en[i] &&
                (ch_data[i*DATA_W +: DATA_W] != shadow[i*DATA_W +: DATA_W])) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                sel       = CH_W'(i);
                sel_value = ch_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign capturing = (state_q == ST_ARMED) || (state_q == ST_POST);
    assign cap       = capturing && found && !arm;
    assign rd_en     = (state_q == ST_DONE) && rd_req && !arm;

    always_comb begin
        wr_entry                           = '0;
        wr_entry[VALUE_LSB +: DATA_W]      = sel_value;
        wr_entry[CH_LSB +: CH_W]           = sel;
        wr_entry[TS_LSB +: TS_W]           = ts;
    end

    trace_ring_buffer #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk     (clk),
        .reset   (reset),
        .clear   (arm),
        .wr_en   (cap),
        .wr_data (wr_entry),
        .rd_en   (rd_en),
        .rd_data (rd_entry),
        .count   (count),
        .full    (full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ts        <= '0;
            shadow    <= '0;
            remaining <= '0;
            rd_valid  <= 1'b0;
            rd_ts     <= '0;
            rd_ch     <= '0;
            rd_value  <= '0;
            overflow  <= 1'b0;
        end else begin
            ts       <= ts + 1'b1;
            rd_valid <= 1'b0;

            if (cap) begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (grant[i]) begin
                        shadow[i*DATA_W +: DATA_W] <= ch_data[i*DATA_W +: DATA_W];
                    end
                end
                if (full) begin
                    overflow <= 1'b1;
                end
            end

            if (arm) begin
                state_q   <= ST_ARMED;
                shadow    <= ch_data;
                overflow  <= 1'b0;
                remaining <= '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: ;
                    ST_ARMED: begin
                        if (trig) begin
                            if (POST_CNT == 0) begin
                                state_q <= ST_DONE;
                            end else begin
                                state_q   <= ST_POST;
                                remaining <= (AW+1)'(POST_CNT);
                            end
                        end
                    end
                    ST_POST: begin
                        if (cap) begin
                            remaining <= remaining - 1'b1;
                            if (remaining == (AW+1)'(1)) begin
                                state_q <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (rd_req && (count != '0)) begin
                            rd_valid <= 1'b1;
                            rd_ts    <= rd_entry[TS_LSB +: TS_W];
                            rd_ch    <= rd_entry[CH_LSB +: CH_W];
                            rd_value <= rd_entry[VALUE_LSB +: DATA_W];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipeline_trace_capture.sv
// Directed bench for pipeline_trace_capture: one instance with POST_CNT=1 and
// one with POST_CNT=0 share all inputs; each scenario checks the relevant one.
module tb_pipeline_trace_capture;

    logic         clk = 1'b0;
    logic         reset;
    logic         arm;
    logic         trig;
    logic [159:0] ch_data;
    logic [4:0]   ch_en;
    logic         rd_req;

    logic         rd_valid1, rd_valid0;
    logic [15:0]  rd_ts1, rd_ts0;
    logic [2:0]   rd_ch1, rd_ch0;
    logic [31:0]  rd_value1, rd_value0;
    logic [4:0]   count1, count0;
    logic [1:0]   state1, state0;
    logic         overflow1, overflow0;

    int n_checks = 0;
    int n_fail   = 0;
    int tb_ts    = 0;

    always #5 clk = ~clk;

    pipeline_trace_capture #(
        .NUM_CH(5), .DATA_W(32), .DEPTH(16), .TS_W(16), .POST_CNT(1)
    ) dut1 (
        .clk(clk), .reset(reset), .arm(arm), .trig(trig), .ch_data(ch_data),
        .ch_en(ch_en), .rd_req(rd_req), .rd_valid(rd_valid1), .rd_ts(rd_ts1),
        .rd_ch(rd_ch1), .rd_value(rd_value1), .count(count1), .state(state1),
        .overflow(overflow1)
    );

    pipeline_trace_capture #(
        .NUM_CH(5), .DATA_W(32), .DEPTH(16), .TS_W(16), .POST_CNT(0)
    ) dut0 (
        .clk(clk), .reset(reset), .arm(arm), .trig(trig), .ch_data(ch_data),
        .ch_en(ch_en), .rd_req(rd_req), .rd_valid(rd_valid0), .rd_ts(rd_ts0),
        .rd_ch(rd_ch0), .rd_value(rd_value0), .count(count0), .state(state0),
        .overflow(overflow0)
    );

    // tb_ts tracks the timestamp the DUT will store at the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        tb_ts++;
    endtask

    task automatic set_ch(input int c, input logic [31:0] v);
        ch_data[c*32 +: 32] = v;
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        arm     = 1'b0;
        trig    = 1'b0;
        rd_req  = 1'b0;
        ch_data = '0;
        ch_en   = '1;
        tick();
        reset = 1'b1;
        tb_ts = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        arm = 1'b0; trig = 1'b0; rd_req = 1'b0; ch_data = '0; ch_en = '1;
        tick();
        tick();
        n_checks++; if (state1 !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state1); end
        n_checks++; if (count1 !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count1); end
        n_checks++; if (overflow1 !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow1); end
        n_checks++; if (rd_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", rd_valid1); end
        n_checks++; if ({rd_ts1, rd_ch1, rd_value1} !== 51'd0) begin
            n_fail++; $display("FAIL reset_rd_fields got ts=%0d ch=%0d val=%0d want 0/0/0", rd_ts1, rd_ch1, rd_value1);
        end
        reset = 1'b1;
        tb_ts = 0;
    endtask

    task automatic test_single_change();
        do_reset();
        tick(); tick(); tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        n_checks++; if (state1 !== 2'd1) begin n_fail++; $display("FAIL single_armed got %0d want 1", state1); end
        tick();
        set_ch(1, 32'd7);
        tick();
        n_checks++; if (count1 !== 5'd1) begin n_fail++; $display("FAIL single_count1 got %0d want 1", count1); end
        trig = 1'b1;
        tick();
        trig = 1'b0;
        n_checks++; if (state1 !== 2'd2) begin n_fail++; $display("FAIL single_post got %0d want 2", state1); end
        tick();
        set_ch(2, 32'd9);
        tick();
        n_checks++; if (state1 !== 2'd3 || count1 !== 5'd2) begin
            n_fail++; $display("FAIL single_done got state=%0d count=%0d want 3/2", state1, count1);
        end
        rd_req = 1'b1;
        tick();
        n_checks++; if (rd_valid1 !== 1'b1 || rd_ts1 !== 16'd5 || rd_ch1 !== 3'd1 || rd_value1 !== 32'd7) begin
            n_fail++; $display("FAIL single_read0 got v=%b ts=%0d ch=%0d val=%0d want 1/5/1/7", rd_valid1, rd_ts1, rd_ch1, rd_value1);
        end
        tick();
        n_checks++; if (rd_valid1 !== 1'b1 || rd_ts1 !== 16'd8 || rd_ch1 !== 3'd2 || rd_value1 !== 32'd9) begin
            n_fail++; $display("FAIL single_read1 got v=%b ts=%0d ch=%0d val=%0d want 1/8/2/9", rd_valid1, rd_ts1, rd_ch1, rd_value1);
        end
        tick();
        n_checks++; if (rd_valid1 !== 1'b0 || count1 !== 5'd0 || rd_ts1 !== 16'd8 || rd_value1 !== 32'd9) begin
            n_fail++; $display("FAIL single_read_empty got v=%b count=%0d ts=%0d val=%0d want 0/0/8/9", rd_valid1, count1, rd_ts1, rd_value1);
        end
        rd_req = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [15:0] exp_ts  [4] = '{16'd1, 16'd2, 16'd3, 16'd5};
        logic [2:0]  exp_ch  [4] = '{3'd0, 3'd3, 3'd4, 3'd2};
        logic [31:0] exp_val [4] = '{32'd11, 32'd33, 32'd45, 32'd5};
        do_reset();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        set_ch(0, 32'd11); set_ch(3, 32'd33); set_ch(4, 32'd44);
        tick();
        set_ch(4, 32'd45);
        tick();
        tick();
        n_checks++; if (count1 !== 5'd3) begin n_fail++; $display("FAIL simul_count got %0d want 3", count1); end
        trig = 1'b1;
        tick();
        trig = 1'b0;
        set_ch(2, 32'd5);
        tick();
        n_checks++; if (state1 !== 2'd3) begin n_fail++; $display("FAIL simul_done got %0d want 3", state1); end
        rd_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (rd_valid1 !== 1'b1 || rd_ts1 !== exp_ts[k] || rd_ch1 !== exp_ch[k] || rd_value1 !== exp_val[k]) begin
                n_fail++;
                $display("FAIL simul_read%0d got v=%b ts=%0d ch=%0d val=%0d want 1/%0d/%0d/%0d",
                         k, rd_valid1, rd_ts1, rd_ch1, rd_value1, exp_ts[k], exp_ch[k], exp_val[k]);
            end
        end
        rd_req = 1'b0;
    endtask

    task automatic test_reset_mid_post();
        do_reset();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        set_ch(2, 32'h21);
        tick();
        set_ch(3, 32'h22);
        tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        n_checks++; if (state1 !== 2'd2 || count1 !== 5'd2) begin
            n_fail++; $display("FAIL midpost_setup got state=%0d count=%0d want 2/2", state1, count1);
        end
        reset = 1'b0;
        #1;
        n_checks++; if (state1 !== 2'd0 || count1 !== 5'd0 || overflow1 !== 1'b0 || rd_valid1 !== 1'b0) begin
            n_fail++; $display("FAIL midpost_async got state=%0d count=%0d ovf=%b v=%b want 0/0/0/0", state1, count1, overflow1, rd_valid1);
        end
        tick();
        reset = 1'b1;
        tb_ts = 0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        set_ch(0, 32'd3);
        tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        set_ch(1, 32'd4);
        tick();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        n_checks++; if (rd_valid1 !== 1'b1 || rd_ts1 !== 16'd1 || rd_ch1 !== 3'd0 || rd_value1 !== 32'd3) begin
            n_fail++; $display("FAIL midpost_ts_restart got v=%b ts=%0d ch=%0d val=%0d want 1/1/0/3", rd_valid1, rd_ts1, rd_ch1, rd_value1);
        end
    endtask

    task automatic test_wrap_overflow();
        do_reset();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int v = 1; v <= 20; v++) begin
            set_ch(0, 32'(v));
            tick();
        end
        trig = 1'b1;
        tick();
        trig = 1'b0;
        n_checks++; if (state0 !== 2'd3 || count0 !== 5'd16 || overflow0 !== 1'b1) begin
            n_fail++; $display("FAIL wrap_status got state=%0d count=%0d ovf=%b want 3/16/1", state0, count0, overflow0);
        end
        rd_req = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            n_checks++;
            if (rd_valid0 !== 1'b1 || rd_value0 !== 32'(k + 5) || rd_ts0 !== 16'(k + 5) || rd_ch0 !== 3'd0) begin
                n_fail++;
                $display("FAIL wrap_read%0d got v=%b ts=%0d ch=%0d val=%0d want 1/%0d/0/%0d",
                         k, rd_valid0, rd_ts0, rd_ch0, rd_value0, k + 5, k + 5);
            end
        end
        tick();
        rd_req = 1'b0;
        n_checks++; if (rd_valid0 !== 1'b0 || count0 !== 5'd0 || overflow0 !== 1'b1) begin
            n_fail++; $display("FAIL wrap_drained got v=%b count=%0d ovf=%b want 0/0/1", rd_valid0, count0, overflow0);
        end
    endtask

    task automatic test_mask_rearm();
        ch_en = 5'b11110;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        n_checks++; if (state1 !== 2'd1 || count1 !== 5'd0) begin
            n_fail++; $display("FAIL mask_armed got state=%0d count=%0d want 1/0", state1, count1);
        end
        n_checks++; if (overflow0 !== 1'b0 || count0 !== 5'd0) begin
            n_fail++; $display("FAIL rearm_clear_ovf got ovf=%b count=%0d want 0/0", overflow0, count0);
        end
        for (int k = 0; k < 4; k++) begin
            set_ch(0, 32'(100 + k));
            tick();
        end
        n_checks++; if (count1 !== 5'd0) begin n_fail++; $display("FAIL mask_ch0 got count=%0d want 0", count1); end
        set_ch(1, 32'h55); set_ch(3, 32'h66);
        set_ch(0, 32'd200);
        tick();
        set_ch(0, 32'd201);
        tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        set_ch(2, 32'h77);
        tick();
        n_checks++; if (state1 !== 2'd3 || count1 !== 5'd3) begin
            n_fail++; $display("FAIL mask_done got state=%0d count=%0d want 3/3", state1, count1);
        end
        arm = 1'b1; rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        n_checks++; if (state1 !== 2'd1 || count1 !== 5'd0 || overflow1 !== 1'b0 || rd_valid1 !== 1'b0) begin
            n_fail++; $display("FAIL rearm_done got state=%0d count=%0d ovf=%b v=%b want 1/0/0/0", state1, count1, overflow1, rd_valid1);
        end
        trig = 1'b1;
        tick();
        arm = 1'b0; trig = 1'b0;
        n_checks++; if (state1 !== 2'd1 || state0 !== 2'd1) begin
            n_fail++; $display("FAIL arm_trig_same got state1=%0d state0=%0d want 1/1", state1, state0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_change();
        test_simultaneous();
        test_reset_mid_post();
        test_wrap_overflow();
        test_mask_rearm();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
